// File: rtl/pkt_rx_parser.sv
// pkt_rx_parser: address-filtering packet parser writing delimiter-terminated payloads to the port FIFO; PKT_RX_STATS_EN adds saturating counters
module pkt_rx_parser #(
  parameter int W_WIDTH = 8,
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_en,
  input  logic [W_WIDTH-1:0] local_addr,
  input  logic [W_WIDTH-1:0] port_in,
  input  logic               fifo_full,
  output logic               wr_en,
  output logic [W_WIDTH-1:0] wr_data,
  output logic [W_WIDTH-1:0] pkt_addr,
  output logic               pkt_done,
  output logic               pkt_drop,
  output logic               pkt_err,
  output logic [15:0]        good_cnt,
  output logic [15:0]        drop_cnt
);
  localparam logic [W_WIDTH-1:0] SOF = W_WIDTH'(8'hFF);
  localparam logic [W_WIDTH-1:0] DELIM = W_WIDTH'(8'h55);
  typedef enum logic [2:0] {IDLE, ADDR, PAYLOAD, TERM, DISCARD} state_t;
  state_t state, state_nx;
  logic [7:0] len;
  logic saw_delim, done_nx, drop_nx, err_nx;
  logic is_delim, len_max;
  assign is_delim = port_in == DELIM;
  assign len_max = len == 8'(MAX_LEN);
  always_comb begin
    state_nx = state;
    wr_en = 1'b0;
    wr_data = port_in;
    done_nx = 1'b0;
    drop_nx = 1'b0;
    err_nx = 1'b0;
    unique case (state)
      IDLE: state_nx = (sw_en && port_in == SOF) ? ADDR : IDLE;
      ADDR: begin
        drop_nx = port_in != local_addr;
        state_nx = drop_nx ? DISCARD : PAYLOAD;
      end
      PAYLOAD: begin
        if (fifo_full || (!is_delim && len_max)) begin
          err_nx = 1'b1;
          state_nx = TERM;
        end else begin
          wr_en = 1'b1;
          done_nx = is_delim;
          state_nx = is_delim ? IDLE : PAYLOAD;
        end
      end
      TERM: begin
        wr_en = !fifo_full;
        wr_data = DELIM;
        state_nx = fifo_full ? TERM : (saw_delim || is_delim) ? IDLE : DISCARD;
      end
      DISCARD: state_nx = is_delim ? IDLE : DISCARD;
      default: state_nx = IDLE;
    endcase
    if (rst) wr_en = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      saw_delim <= 1'b0;
      pkt_addr <= '0;
      pkt_done <= 1'b0;
      pkt_drop <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      state <= state_nx;
      pkt_done <= done_nx;
      pkt_drop <= drop_nx;
      pkt_err <= err_nx;
      if (state == ADDR) begin
        pkt_addr <= port_in;
        len <= '0;
      end
      if (state == PAYLOAD && wr_en && !is_delim) len <= len + 8'd1;
      if (state == PAYLOAD && err_nx) saw_delim <= fifo_full && is_delim;
      else if (state == TERM && is_delim) saw_delim <= 1'b1;
    end
  end
`ifdef PKT_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (done_nx && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      if ((drop_nx || err_nx) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign good_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_rx_parser.sv
// tb_pkt_rx_parser: directed vectors checked against a packet-level stream model
module tb_pkt_rx_parser;
  localparam int MAXL = 2;
`ifdef PKT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sw_en = 1'b0, fifo_full = 1'b0;
  logic [7:0] local_addr = 8'h03, port_in = 8'h00;
  logic wr_en, pkt_done, pkt_drop, pkt_err;
  logic [7:0] wr_data, pkt_addr;
  logic [15:0] good_cnt, drop_cnt;
  pkt_rx_parser #(.W_WIDTH(8), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .sw_en(sw_en), .local_addr(local_addr), .port_in(port_in),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data), .pkt_addr(pkt_addr),
    .pkt_done(pkt_done), .pkt_drop(pkt_drop), .pkt_err(pkt_err),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, cur = 0;
  bit active = 1'b0;
  logic [7:0] vb[40];
  bit vf[40], vs[40];
  int n;
  bit ewe[40], edn[40], edr[40], eer[40], cap[40];
  logic [7:0] ewd[40], capv[40], ea[40];
  int eg[40], ed[40];
  logic [7:0] m_addr = 8'h00;
  int m_good = 0, m_bad = 0;
  logic [7:0] wq[$];
  int done_cyc[$];
  int n_drop = 0, n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, a, e);
    end
  endtask
  task automatic ld(input logic [8*16-1:0] bytes, input int cnt);
    n = cnt;
    for (int k = 0; k < cnt; k++) begin
      vb[k] = bytes[8*(cnt-1-k) +: 8];
      vf[k] = 1'b0;
      vs[k] = 1'b1;
    end
  endtask
  task automatic model();
    int i, len;
    bit sd, term;
    for (int k = 0; k < 40; k++) begin
      ewe[k] = 0; edn[k] = 0; edr[k] = 0; eer[k] = 0; cap[k] = 0; ewd[k] = 8'h00; capv[k] = 8'h00;
    end
    i = 0;
    sd = 0;
    while (i < n) begin
      if (!(vs[i] && vb[i] == 8'hFF)) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) break;
      cap[i+1] = 1;
      capv[i+1] = vb[i];
      if (vb[i] != local_addr) begin
        edr[i+1] = 1;
        i++;
        while (i < n && vb[i] != 8'h55) i++;
        i++;
        continue;
      end
      i++;
      len = 0;
      term = 0;
      while (i < n) begin
        if (vf[i]) begin
          eer[i+1] = 1; sd = vb[i] == 8'h55; term = 1; i++;
          break;
        end
        if (vb[i] == 8'h55) begin
          ewe[i] = 1; ewd[i] = 8'h55; edn[i+1] = 1; i++;
          break;
        end
        if (len == MAXL) begin
          eer[i+1] = 1; sd = 0; term = 1; i++;
          break;
        end
        ewe[i] = 1; ewd[i] = vb[i]; len++; i++;
      end
      if (term) begin
        while (i < n && vf[i]) begin
          if (vb[i] == 8'h55) sd = 1;
          i++;
        end
        if (i < n) begin
          ewe[i] = 1;
          ewd[i] = 8'h55;
          if (!(sd || vb[i] == 8'h55)) begin
            i++;
            while (i < n && vb[i] != 8'h55) i++;
          end
          i++;
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      if (cap[k]) m_addr = capv[k];
      if (edn[k] && m_good < 65535) m_good++;
      if ((edr[k] || eer[k]) && m_bad < 65535) m_bad++;
      ea[k] = m_addr;
      eg[k] = m_good;
      ed[k] = m_bad;
    end
  endtask
  function automatic int model_writes();
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(ewe[k]);
    return c;
  endfunction
  function automatic logic [31:0] wq_pack();
    logic [31:0] p = 32'h0;
    foreach (wq[k]) p = {p[23:0], wq[k]};
    return p;
  endfunction
  task automatic run_vec();
    model();
    wq.delete();
    done_cyc.delete();
    n_drop = 0;
    n_err = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      port_in = vb[i];
      fifo_full = vf[i];
      sw_en = vs[i];
      cur = i;
      active = 1'b1;
    end
    @(posedge clk);
    #1;
    active = 1'b0;
    fifo_full = 1'b0;
    sw_en = 1'b1;
    port_in = 8'h00;
  endtask
  always @(negedge clk) begin
    if (active) begin
      chk("wr_en", 32'(wr_en), 32'(ewe[cur]));
      if (ewe[cur]) chk("wr_data", 32'(wr_data), 32'(ewd[cur]));
      chk("pkt_done", 32'(pkt_done), 32'(edn[cur]));
      chk("pkt_drop", 32'(pkt_drop), 32'(edr[cur]));
      chk("pkt_err", 32'(pkt_err), 32'(eer[cur]));
      chk("pkt_addr", 32'(pkt_addr), 32'(ea[cur]));
      chk("good_cnt", 32'(good_cnt), STATS ? 32'(eg[cur]) : 32'h0);
      chk("drop_cnt", 32'(drop_cnt), STATS ? 32'(ed[cur]) : 32'h0);
      if (wr_en) wq.push_back(wr_data);
      if (pkt_done) done_cyc.push_back(cyc);
      if (pkt_drop) n_drop++;
      if (pkt_err) n_err++;
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    port_in = 8'hFF;
    sw_en = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_addr", 32'(pkt_addr), 32'h0);
    chk("rst_pulses", {29'h0, pkt_done, pkt_drop, pkt_err}, 32'h0);
    chk("rst_cnt", {good_cnt, drop_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    port_in = 8'h00;
    ld(128'h00FF031122550000, 8);
    run_vec();
    chk("m1_nwr", model_writes(), 3);
    chk("v1_nwr", wq.size(), 3);
    chk("v1_data", wq_pack(), 32'h00112255);
    chk("v1_ndone", done_cyc.size(), 1);
    chk("v1_addr", 32'(pkt_addr), 32'h03);
    chk("v1_good", 32'(good_cnt), STATS ? 32'h1 : 32'h0);
    ld(128'hFF0711FF5500FF03AA550000, 12);
    run_vec();
    chk("v2_data", wq_pack(), 32'h0000AA55);
    chk("v2_ndrop", n_drop, 1);
    ld(128'hFF0301020304550000, 9);
    run_vec();
    chk("m3_nwr", model_writes(), 3);
    chk("v3_data", wq_pack(), 32'h00010255);
    chk("v3_nerr", n_err, 1);
    ld(128'hFF03010203550000, 8);
    run_vec();
    chk("v3b_data", wq_pack(), 32'h00010255);
    ld(128'hFF0311223355000000, 9);
    vf[3] = 1; vf[4] = 1; vf[5] = 1;
    run_vec();
    chk("v4_data", wq_pack(), 32'h00001155);
    chk("v4_nerr", n_err, 1);
    ld(128'hFF0311550000, 6);
    for (int k = 0; k < 6; k++) vs[k] = 1'b0;
    run_vec();
    chk("v5_nwr", wq.size(), 0);
    ld(128'hFF0311550000, 6);
    for (int k = 1; k < 6; k++) vs[k] = 1'b0;
    run_vec();
    chk("v5b_data", wq_pack(), 32'h00001155);
    ld(128'hFFFF22550000, 6);
    run_vec();
    chk("v6_nwr", wq.size(), 0);
    chk("v6_addr", 32'(pkt_addr), 32'hFF);
    @(posedge clk); #1; port_in = 8'hFF;
    @(posedge clk); #1; port_in = 8'h03;
    @(posedge clk); #1; port_in = 8'h11;
    @(negedge clk);
    chk("pre_rst_wr", 32'(wr_en), 32'h1);
    @(posedge clk); #1; port_in = 8'h22; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr", 32'(wr_en), 32'h0);
    @(posedge clk); #1; port_in = 8'h55; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(wr_en), 32'h0);
    chk("post_rst_addr", 32'(pkt_addr), 32'h0);
    chk("post_rst_cnt", {good_cnt, drop_cnt}, 32'h0);
    @(posedge clk); #1; port_in = 8'h00;
    @(negedge clk);
    chk("post_rst_pulses", {29'h0, pkt_done, pkt_drop, pkt_err}, 32'h0);
    m_addr = 8'h00;
    m_good = 0;
    m_bad = 0;
    ld(128'hFF03AA55FF03BB550000, 10);
    run_vec();
    chk("v7_data", wq_pack(), 32'hAA55BB55);
    chk("v7_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("v7_gap", done_cyc[1] - done_cyc[0], 4);
    chk("v7_good", 32'(good_cnt), STATS ? 32'h2 : 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
